pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Parametrised successor to the fixed single-cycle hazard detection and forwarding logic of the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Generates EX-stage and ID-stage forwarding selects, load-use and branch-in-ID stalls, taken-branch flushes, and whole-pipeline freeze for a variable-latency data memory.
- Sits beside the pipeline registers; drives PC, IF_ID, ID_EX, EX_MEM and MEM_WB write/flush controls.

Parameters:
- REG_ADDR_W, 5, register-index width.
- LOAD_LAT, 1, load-use stall length in cycles (1..7).
- MAX_WAIT, 255, dmem wait cycles before timeout flag (1..255).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- id_rs1_i, id_rs2_i  in  REG_ADDR_W  source registers of instruction in ID.
- id_use_rs1_i, id_use_rs2_i  in  1  instruction in ID reads rs1/rs2.
- id_branch_i  in  1  ID holds a branch.
- id_branch_taken_i  in  1  branch compare result in ID (already forwarded).
- ex_rs1_i, ex_rs2_i, ex_rd_i  in  REG_ADDR_W  ID_EX register fields.
- ex_regwrite_i, ex_memread_i  in  1  ID_EX controls.
- mem_rd_i  in  REG_ADDR_W; mem_regwrite_i, mem_memread_i, mem_req_i  in  1  EX_MEM fields; mem_req_i = load or store.
- wb_rd_i  in  REG_ADDR_W; wb_regwrite_i  in  1  MEM_WB fields.
- dmem_ready_i  in  1  data memory completes access this cycle.
- fwd_a_o, fwd_b_o  out  2  EX operand select: 00 regfile, 01 MEM_WB, 10 EX_MEM.
- fwd_id_a_o, fwd_id_b_o  out  2  ID branch-compare select, same encoding.
- pc_write_o, if_id_write_o  out  1  enables.
- if_id_flush_o, id_ex_bubble_o, mem_wb_bubble_o  out  1  insert NOP.
- ex_mem_hold_o, id_ex_hold_o  out  1  hold register.
- mem_timeout_o  out  1  sticky timeout flag.

Behaviour:
- Forwarding (combinational): a source equal to x0 is never forwarded. EX_MEM match (mem_regwrite_i, mem_rd_i == source) beats MEM_WB match. An EX_MEM match on a load (mem_memread_i) is excluded from EX_MEM forwarding. fwd_id_* uses the same rules against EX_MEM/MEM_WB for id_rs*.
- freeze = mem_req_i & ~dmem_ready_i; highest priority.
  - Effect: pc_write_o = if_id_write_o = 0, id_ex_hold_o = ex_mem_hold_o = 1, mem_wb_bubble_o = 1, flush suppressed.
- FSM states: RUN, LU_STALL. A 3-bit stall counter supports the load-use stall.
  - RUN, no freeze, load-use hazard (ex_memread_i, ex_rd_i != 0, matches a used id_rs*):
    - Assert stall this cycle.
    - Load cnt = LOAD_LAT-1.
    - If cnt != 0, go to LU_STALL.
  - LU_STALL: assert stall while cnt != 0; decrement each non-frozen cycle; return to RUN when cnt reaches 0.
  - Freeze pauses the counter.
- Branch stall (RUN only), one cycle, asserted when id_branch_i and either:
  - an EX match with ex_regwrite_i, or
  - a MEM match with mem_memread_i.
- Stall effect: pc_write_o = if_id_write_o = 0, id_ex_bubble_o = 1.
- Flush: if_id_flush_o = id_branch_taken_i & id_branch_i & ~stall & ~freeze, for one cycle.
- Priority: freeze > stall > flush.
- Timeout: wait_cnt (8 bit) increments while freeze and clears when not frozen. When wait_cnt == MAX_WAIT, set mem_timeout_o; it stays set until reset.
- Reset values (async):
  - State RUN; counters 0; mem_timeout_o 0.
  - Outputs: pc_write_o = if_id_write_o = 1; all other controls 0; fwd selects 00.
  - Reset mid-stall returns to RUN immediately.

Optional Feature:
- PERF_CNT_EN defined: adds 32-bit saturating counters exposed as outputs perf_stall_o, perf_flush_o, perf_freeze_o. Each increments once per cycle that its condition is active. All reset to 0.
- Undefined: the counters and their ports do not exist.

Decomposition:
- Shared package pipe_pkg: fwd_sel_t enum (FWD_REG, FWD_WB, FWD_MEM), hz_state_t (RUN, LU_STALL), OPC_LOAD/OPC_BRANCH constants.
- One sub-module: forward_sel, instantiated twice (EX and ID), containing the per-operand priority compare.

Test Plan:
- add x5 in EX_MEM, add using x5 in ID_EX -> fwd_a_o = 10; same rd also in MEM_WB -> still 10; rd = x0 -> 00.
- lw x6 in ID_EX, add x7,x6,x1 in ID, LOAD_LAT = 3 -> pc_write_o = 0 and id_ex_bubble_o = 1 for exactly 3 cycles, then resume with fwd = 01.
- beq x6 in ID with add x6 in EX -> 1 stall; next cycle fwd_id_a_o = 10; taken -> if_id_flush_o high 1 cycle.
- mem_req_i = 1, dmem_ready_i low 4 cycles -> freeze 4 cycles, mem_wb_bubble_o = 1; a concurrent load-use counter does not decrement.
- MAX_WAIT = 5, ready held low -> mem_timeout_o rises on cycle 6 and stays after ready returns; rst_n_i low mid-LU_STALL -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard/forwarding control
//   fwd_sel_t  : operand source select (regfile, MEM_WB, EX_MEM)
//   hz_state_t : hazard controller states (RUN, LU_STALL)
//   OPC_*      : RV32 major opcodes used by the decode side to build use/branch/load flags
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// forward_sel: priority forwarding select for a pair of source operands
//   a_i, b_i                 : source register indices
//   mem_rd_i, mem_regwrite_i : EX_MEM destination and write enable
//   mem_memread_i            : EX_MEM holds a load (its data is not ready yet)
//   wb_rd_i, wb_regwrite_i   : MEM_WB destination and write enable
//   sel_a_o, sel_b_o         : 00 regfile, 01 MEM_WB, 10 EX_MEM
module forward_sel
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] a_i,
    input  logic [REG_ADDR_W-1:0] b_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_regwrite_i,
    input  logic                  mem_memread_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_regwrite_i,
    output logic [1:0]            sel_a_o,
    output logic [1:0]            sel_b_o
);

    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // A load in EX_MEM has no result yet, so it never forwards from that stage.
    assign mem_hit_a = mem_regwrite_i & ~mem_memread_i & (a_i != '0) & (mem_rd_i == a_i);
    assign mem_hit_b = mem_regwrite_i & ~mem_memread_i & (b_i != '0) & (mem_rd_i == b_i);
    assign wb_hit_a  = wb_regwrite_i & (a_i != '0) & (wb_rd_i == a_i);
    assign wb_hit_b  = wb_regwrite_i & (b_i != '0) & (wb_rd_i == b_i);

    assign sel_a_o = mem_hit_a ? FWD_MEM : wb_hit_a ? FWD_WB : FWD_REG;
    assign sel_b_o = mem_hit_b ? FWD_MEM : wb_hit_b ? FWD_WB : FWD_REG;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, forwarding and stall/flush/freeze control for a 5-stage pipeline
//   clk_i, rst_n_i            : clock, asynchronous active-low reset
//   id_*                      : sources, use flags and branch info of the instruction in ID
//   ex_*, mem_*, wb_*         : ID_EX, EX_MEM and MEM_WB register fields
//   dmem_ready_i              : data memory finishes the pending access this cycle
//   fwd_a_o/fwd_b_o           : EX operand selects; fwd_id_a_o/fwd_id_b_o : ID compare selects
//   pc_write_o, if_id_write_o : fetch/decode advance enables
//   if_id_flush_o, id_ex_bubble_o, mem_wb_bubble_o : NOP insertion
//   id_ex_hold_o, ex_mem_hold_o : register holds during a memory freeze
//   mem_timeout_o             : sticky data-memory timeout
// Optional build macro PERF_CNT_EN adds saturating counters perf_stall_o, perf_flush_o, perf_freeze_o.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic                  id_branch_i,
    input  logic                  id_branch_taken_i,
    input  logic [REG_ADDR_W-1:0] ex_rs1_i,
    input  logic [REG_ADDR_W-1:0] ex_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_regwrite_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_regwrite_i,
    input  logic                  mem_memread_i,
    input  logic                  mem_req_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_regwrite_i,
    input  logic                  dmem_ready_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic [1:0]            fwd_id_a_o,
    output logic [1:0]            fwd_id_b_o,
    output logic                  pc_write_o,
    output logic                  if_id_write_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic                  mem_wb_bubble_o,
    output logic                  ex_mem_hold_o,
    output logic                  id_ex_hold_o,
    output logic                  mem_timeout_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_o,
    output logic [31:0]           perf_flush_o,
    output logic [31:0]           perf_freeze_o
`endif
);

    localparam logic [2:0] LU_INIT  = 3'(LOAD_LAT - 1);
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    hz_state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] wait_q;
    logic       timeout_q;
    logic       freeze, stall, flush, ex_match, mem_match, lu_hz, br_hz;
    logic [1:0] fa, fb, fia, fib;

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_ex (
        .a_i            (ex_rs1_i),
        .b_i            (ex_rs2_i),
        .mem_rd_i       (mem_rd_i),
        .mem_regwrite_i (mem_regwrite_i),
        .mem_memread_i  (mem_memread_i),
        .wb_rd_i        (wb_rd_i),
        .wb_regwrite_i  (wb_regwrite_i),
        .sel_a_o        (fa),
        .sel_b_o        (fb)
    );

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_id (
        .a_i            (id_rs1_i),
        .b_i            (id_rs2_i),
        .mem_rd_i       (mem_rd_i),
        .mem_regwrite_i (mem_regwrite_i),
        .mem_memread_i  (mem_memread_i),
        .wb_rd_i        (wb_rd_i),
        .wb_regwrite_i  (wb_regwrite_i),
        .sel_a_o        (fia),
        .sel_b_o        (fib)
    );

    // Destination of EX / MEM is read by the ID instruction (x0 never creates a dependency).
    assign ex_match  = (ex_rd_i != '0) &
                       ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    assign mem_match = (mem_rd_i != '0) &
                       ((id_use_rs1_i & (id_rs1_i == mem_rd_i)) | (id_use_rs2_i & (id_rs2_i == mem_rd_i)));
    assign lu_hz     = ex_memread_i & ex_match;
    assign br_hz     = id_branch_i & ((ex_regwrite_i & ex_match) | (mem_memread_i & mem_match));

    // Controls are forced to their idle values while reset is held so the pipeline sees a clean reset.
    assign freeze = rst_n_i & mem_req_i & ~dmem_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (rst_n_i && !freeze) begin
            if (state_q == RUN) begin
                stall = lu_hz | br_hz;
                if (lu_hz) begin
                    cnt_d   = LU_INIT;
                    state_d = (LU_INIT != 3'd0) ? LU_STALL : RUN;
                end
            end else begin
                stall   = cnt_q != 3'd0;
                cnt_d   = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
                state_d = (cnt_q <= 3'd1) ? RUN : LU_STALL;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RUN;
            cnt_q     <= 3'd0;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= freeze ? wait_q + {7'd0, wait_q != 8'hFF} : 8'd0;
            if (wait_q == WAIT_LIM) timeout_q <= 1'b1;
        end
    end

    assign flush           = rst_n_i & id_branch_taken_i & id_branch_i & ~stall & ~freeze;
    assign fwd_a_o         = {2{rst_n_i}} & fa;
    assign fwd_b_o         = {2{rst_n_i}} & fb;
    assign fwd_id_a_o      = {2{rst_n_i}} & fia;
    assign fwd_id_b_o      = {2{rst_n_i}} & fib;
    assign pc_write_o      = ~(freeze | stall);
    assign if_id_write_o   = ~(freeze | stall);
    assign if_id_flush_o   = flush;
    assign id_ex_bubble_o  = stall;
    assign mem_wb_bubble_o = freeze;
    assign ex_mem_hold_o   = freeze;
    assign id_ex_hold_o    = freeze;
    // The flag rises in the cycle the limit is reached, then the sticky bit keeps it.
    assign mem_timeout_o   = timeout_q | (wait_q == WAIT_LIM);

`ifdef PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_stall_o  <= 32'd0;
            perf_flush_o  <= 32'd0;
            perf_freeze_o <= 32'd0;
        end else begin
            perf_stall_o  <= perf_stall_o + {31'd0, stall & ~&perf_stall_o};
            perf_flush_o  <= perf_flush_o + {31'd0, flush & ~&perf_flush_o};
            perf_freeze_o <= perf_freeze_o + {31'd0, freeze & ~&perf_freeze_o};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench with a cycle model of the hazard rules
module tb_pipeline_hazard_ctrl;

    localparam int W  = 5;
    localparam int LL = 3;
    localparam int MW = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic u1, u2, br, tk, ex_rw, ex_mr, mem_rw, mem_mr, mem_req, wb_rw, rdy;
    logic [1:0] fwd_a, fwd_b, fwd_id_a, fwd_id_b;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_wb_bubble, ex_mem_hold, id_ex_hold, mem_timeout;

    int total = 0, bad = 0;
    int left = 0, frz_run = 0;
    bit seen = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_W(W), .LOAD_LAT(LL), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(u1), .id_use_rs2_i(u2),
        .id_branch_i(br), .id_branch_taken_i(tk),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_rw), .ex_memread_i(ex_mr),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_rw), .mem_memread_i(mem_mr), .mem_req_i(mem_req),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_rw), .dmem_ready_i(rdy),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .fwd_id_a_o(fwd_id_a), .fwd_id_b_o(fwd_id_b),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
        .id_ex_bubble_o(id_ex_bubble), .mem_wb_bubble_o(mem_wb_bubble),
        .ex_mem_hold_o(ex_mem_hold), .id_ex_hold_o(id_ex_hold), .mem_timeout_o(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [W-1:0] s);
        if (s == 0) return 2'b00;
        if (mem_rw && !mem_mr && mem_rd == s) return 2'b10;
        if (wb_rw && wb_rd == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit reads(input logic [W-1:0] r);
        return r != 0 && ((u1 && id_rs1 == r) || (u2 && id_rs2 == r));
    endfunction

    function automatic bit frz();
        return rst_n && mem_req && !rdy;
    endfunction

    function automatic bit lu();
        return ex_mr && reads(ex_rd);
    endfunction

    // Model state: stall cycles still owed after the current one, consecutive frozen cycles, sticky timeout.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left    <= 0;
            frz_run <= 0;
            seen    <= 0;
        end else begin
            if (!frz()) left <= (left > 0) ? left - 1 : (lu() ? LL - 1 : 0);
            frz_run <= frz() ? frz_run + 1 : 0;
            if (frz_run >= MW) seen <= 1;
        end
    end

    always @(negedge clk) begin
        bit f, s;
        f = frz();
        s = rst_n && !f && (left > 0 || lu() || (br && ((ex_rw && reads(ex_rd)) || (mem_mr && reads(mem_rd)))));
        check("m_fwd_a", fwd_a, rst_n ? fwd(ex_rs1) : 2'b00);
        check("m_fwd_b", fwd_b, rst_n ? fwd(ex_rs2) : 2'b00);
        check("m_fwd_id_a", fwd_id_a, rst_n ? fwd(id_rs1) : 2'b00);
        check("m_fwd_id_b", fwd_id_b, rst_n ? fwd(id_rs2) : 2'b00);
        check("m_pc_write", pc_write, !(f || s));
        check("m_if_id_write", if_id_write, !(f || s));
        check("m_bubble", id_ex_bubble, s);
        check("m_flush", if_id_flush, rst_n && br && tk && !s && !f);
        check("m_mwb_bubble", mem_wb_bubble, f);
        check("m_holds", {ex_mem_hold, id_ex_hold}, {f, f});
        check("m_timeout", mem_timeout, rst_n && (seen || frz_run >= MW));
    end

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {u1, u2, br, tk, ex_rw, ex_mr, mem_rw, mem_mr, mem_req, wb_rw} = '0;
        rdy = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        @(negedge clk);
        check("rst_pc_write", pc_write, 1);
        check("rst_bubble", id_ex_bubble, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step(); ex_rs1 = 5; mem_rd = 5; mem_rw = 1;
        @(negedge clk); check("fwd_mem", fwd_a, 2'b10);
        step(); wb_rd = 5; wb_rw = 1;
        @(negedge clk); check("fwd_mem_over_wb", fwd_a, 2'b10);
        step(); mem_mr = 1;
        @(negedge clk); check("fwd_load_excluded", fwd_a, 2'b01);
        step(); ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_mr = 0;
        @(negedge clk); check("fwd_x0", fwd_a, 2'b00);
        step(); idle(); ex_rs2 = 7; wb_rd = 7; wb_rw = 1; id_rs2 = 7;
        @(negedge clk); check("fwd_b_wb", fwd_b, 2'b01); check("fwd_id_b_wb", fwd_id_b, 2'b01);

        step(); idle(); ex_mr = 1; ex_rw = 1; ex_rd = 6; id_rs1 = 6; u1 = 1; id_rs2 = 1; u2 = 1;
        @(negedge clk); check("lu_c1_pc", pc_write, 0); check("lu_c1_bubble", id_ex_bubble, 1);
        step(); ex_mr = 0; ex_rw = 0; ex_rd = 0;
        @(negedge clk); check("lu_c2_pc", pc_write, 0);
        step();
        @(negedge clk); check("lu_c3_pc", pc_write, 0);
        step(); ex_rs1 = 6; wb_rd = 6; wb_rw = 1; id_rs1 = 0; u1 = 0;
        @(negedge clk); check("lu_resume_pc", pc_write, 1); check("lu_resume_fwd", fwd_a, 2'b01);

        step(); idle(); br = 1; tk = 1; id_rs1 = 6; u1 = 1; ex_rd = 6; ex_rw = 1;
        @(negedge clk); check("br_stall", pc_write, 0); check("br_stall_noflush", if_id_flush, 0);
        step(); ex_rd = 0; ex_rw = 0; mem_rd = 6; mem_rw = 1;
        @(negedge clk); check("br_go", pc_write, 1); check("br_fwd_id", fwd_id_a, 2'b10);
        check("br_flush", if_id_flush, 1);
        step(); br = 0; tk = 0;
        @(negedge clk); check("br_flush_end", if_id_flush, 0);
        step(); br = 1; mem_mr = 1;
        @(negedge clk); check("br_load_in_mem", pc_write, 0);

        step(); idle(); ex_mr = 1; ex_rd = 6; id_rs1 = 6; u1 = 1;
        @(negedge clk); check("frz_lu_start", id_ex_bubble, 1);
        for (int i = 0; i < 4; i++) begin
            step(); ex_mr = 0; ex_rd = 0; mem_req = 1; rdy = 0;
            @(negedge clk);
            check("frz_pc", pc_write, 0); check("frz_mwb", mem_wb_bubble, 1); check("frz_no_bubble", id_ex_bubble, 0);
        end
        step(); mem_req = 0; rdy = 1;
        @(negedge clk); check("frz_lu_left1", id_ex_bubble, 1);
        step();
        @(negedge clk); check("frz_lu_left2", id_ex_bubble, 1);
        step();
        @(negedge clk); check("frz_lu_done", pc_write, 1); check("frz_no_timeout", mem_timeout, 0);

        for (int i = 1; i <= 6; i++) begin
            step(); mem_req = 1; rdy = 0;
            @(negedge clk); check($sformatf("tmo_c%0d", i), mem_timeout, i == 6);
        end
        step(); mem_req = 0; rdy = 1;
        @(negedge clk); check("tmo_sticky", mem_timeout, 1);

        step(); idle(); ex_mr = 1; ex_rd = 6; id_rs1 = 6; u1 = 1;
        @(negedge clk); check("rst_lu_start", id_ex_bubble, 1);
        step(); ex_mr = 0; ex_rd = 0; br = 1; tk = 1; ex_rs1 = 5; mem_rd = 5; mem_rw = 1;
        @(negedge clk); check("rst_lu_stalled", id_ex_bubble, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", pc_write, 1); check("arst_bubble", id_ex_bubble, 0);
        check("arst_flush", if_id_flush, 0); check("arst_fwd", fwd_a, 2'b00);
        check("arst_timeout", mem_timeout, 0);
        step(); idle(); rst_n = 1'b1;
        @(negedge clk); check("post_rst_run", pc_write, 1); check("post_rst_bubble", id_ex_bubble, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
